platform_key_conditioner: RTL
=============================

Name: platform_key_conditioner

Overview:
- Conditions the four raw password push-button/switch inputs before they reach the password PIO input port.
- Per-lane flow: two-flop synchroniser, then a polarity fix, then a debounce state machine with a minimum-assertion hold.
- Output key_state[3:0] drives the PIO in_port directly. The PIO interrupt is level-sensitive, so every qualified press is held high long enough for software to see it.
- press_pulse gives a one-cycle strobe per qualified press for local logic.

Parameters:
- WIDTH, 4, number of key lanes.
- DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples needed to accept a press or a release; legal range 1 or more.
- HOLD_CYCLES, 1024, minimum cycles key_state stays high after a press is accepted; 0 means no hold phase.
- ACTIVE_LOW, 1, 1 = a raw key reads 0 when pressed (board buttons); 0 = pressed reads 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = lanes run; 0 = all lanes forced idle.
- key_raw  input  WIDTH  asynchronous raw key levels from the board.
- key_state  output  WIDTH  debounced, held key levels to the PIO in_port; 1 = pressed.
- press_pulse  output  WIDTH  one-cycle strobe on each 0->1 of key_state.
- any_active  output  1  OR-reduction of key_state.

Behaviour:
- Synchroniser, per lane: sync1 <= key_raw, then sync2 <= sync1.
  - s = sync2 XOR ACTIVE_LOW, so s = 1 means pressed.
  - On reset, sync1 and sync2 load ACTIVE_LOW, so s = 0.
- Per-lane FSM uses one counter cnt. Counter width is clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES) + 1). The counter saturates and never wraps.
- IDLE (out 0):
  - s=1: go to ARM, cnt=1; if DEBOUNCE_CYCLES=1, go straight to the HOLD entry instead.
- ARM (out 0):
  - s=0: go to IDLE, cnt=0.
  - s=1 and cnt+1 == DEBOUNCE_CYCLES: go to HOLD, cnt=0, press_pulse high next cycle.
  - otherwise: cnt++.
- HOLD (out 1):
  - s is ignored.
  - cnt == HOLD_CYCLES-1: go to ACTIVE, cnt=0; else cnt++.
  - HOLD_CYCLES=0: a qualified press enters ACTIVE directly.
- ACTIVE (out 1):
  - s=0: go to DISARM, cnt=1; if DEBOUNCE_CYCLES=1, go straight to IDLE.
- DISARM (out 1):
  - s=1: go to ACTIVE, cnt=0.
  - s=0 and cnt+1 == DEBOUNCE_CYCLES: go to IDLE.
  - otherwise: cnt++.
- Output timing:
  - key_state and press_pulse are registered.
  - key_state = 1 exactly in HOLD, ACTIVE and DISARM.
- Press latency: count the first edge that samples the new key_raw into sync1 as edge 1. key_state rises after edge DEBOUNCE_CYCLES+2, provided key_raw stays stable.
- Minimum high time of key_state: HOLD_CYCLES + DEBOUNCE_CYCLES cycles. Release samples taken during HOLD do not count.
- press_pulse:
  - High for exactly the one cycle in which key_state first reads 1.
  - Never high for a lane that was already high.
  - Never high during reset or while enable=0.
- Glitches:
  - A press shorter than DEBOUNCE_CYCLES samples produces no output.
  - A release glitch in DISARM returns the lane to ACTIVE and clears cnt; key_state stays 1.
- Lanes are fully independent. Simultaneous presses on several lanes give simultaneous pulses.
- enable=0:
  - Next edge: every lane goes to IDLE, cnt=0, key_state=0, press_pulse=0. This applies even mid-HOLD.
  - Synchronisers keep running.
  - When enable returns to 1, a key that is still held must re-qualify through the full DEBOUNCE_CYCLES.
- reset=1 at any time, including mid-HOLD or mid-DISARM: next edge all lanes go to IDLE, cnt=0, and all outputs are 0. The reset values of key_state, press_pulse and any_active are all 0.
- any_active is registered. It is identical to the OR of the registered key_state bits in the same cycle.

Test Plan:
- Clean press (DEBOUNCE=4, HOLD=8, ACTIVE_LOW=1): key_raw[0] goes 1->0 and stays.
  - key_state[0] rises after edge 6; press_pulse[0] is high for 1 cycle; any_active=1.
- Bounce rejection (same parameters): key_raw[1] low for 3 cycles, high for 2, then low steady.
  - No output during the bounce.
  - key_state[1] rises 6 edges after the final low is first sampled; exactly one pulse.
- Hold enforcement (same parameters): key_raw[2] press accepted, then released on the next cycle.
  - key_state[2] stays high 8 + 4 = 12 cycles, then falls.
  - No second pulse.
- Release glitch (same parameters): lane 3 in ACTIVE, 2 released samples, 1 pressed sample, then released steady.
  - key_state[3] stays 1 through the glitch.
  - Falls 4 samples after the steady release begins.
- Enable and reset mid-operation (same parameters):
  - Drop enable mid-HOLD: key_state goes to 0 next edge.
  - Raise enable with the key still held: rise after 4 fresh samples, new pulse.
  - Assert reset mid-DISARM: all outputs 0 next edge.
- Polarity and multi-lane (ACTIVE_LOW=0, DEBOUNCE=1, HOLD=0): key_raw=4'b1010 applied on one edge.
  - key_state=4'b1010 after edge 3; press_pulse=4'b1010 for one cycle.

Source files
------------

// File: rtl/platform_key_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module   : platform_key_conditioner_if
//  Purpose  : Key-conditioner bus. Carries the raw key levels and the run
//             enable into the conditioner, and the conditioned key levels,
//             press strobes and activity flag back out.
//  Revision : 1.0 - initial release
// ============================================================================
interface platform_key_conditioner_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic [WIDTH-1:0] key_raw;
    logic [WIDTH-1:0] key_state;
    logic [WIDTH-1:0] press_pulse;
    logic             any_active;

    // Board / system side: drives the raw keys and the enable.
    modport master (
        output enable,
        output key_raw,
        input  key_state,
        input  press_pulse,
        input  any_active
    );

    // Conditioner side.
    modport slave (
        input  enable,
        input  key_raw,
        output key_state,
        output press_pulse,
        output any_active
    );
endinterface
`default_nettype wire

// File: rtl/platform_key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : platform_key_conditioner
//  Purpose  : Per-lane two-flop synchroniser, polarity fix and debounce FSM
//             with a minimum-assertion hold, feeding the password PIO in_port.
//             Every accepted press stays high long enough for software
//             servicing a level-sensitive interrupt to observe it.
//  Revision : 1.0 - initial release
// ============================================================================
module platform_key_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1024,
    parameter int ACTIVE_LOW      = 1
) (
    input wire                         clk,
    input wire                         reset,
    platform_key_conditioner_if.slave  kbus
);

    // One counter per lane serves both the debounce and the hold phases.
    localparam int c_CNT_MAX_VAL = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int c_CNT_W       = $clog2(c_CNT_MAX_VAL + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    // Counter value at which the next agreeing sample completes debounce.
    localparam logic [c_CNT_W-1:0] c_DEB_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    // Counter value on the last hold cycle (unused when there is no hold).
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);

    localparam logic c_POL     = (ACTIVE_LOW != 0);
    localparam logic c_DEB_ONE = (DEBOUNCE_CYCLES == 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_ARM    = 3'd1;
    localparam logic [2:0] c_S_HOLD   = 3'd2;
    localparam logic [2:0] c_S_ACTIVE = 3'd3;
    localparam logic [2:0] c_S_DISARM = 3'd4;

    // A qualified press skips the hold phase entirely when none is configured.
    localparam logic [2:0] c_S_ENTRY = (HOLD_CYCLES == 0) ? c_S_ACTIVE : c_S_HOLD;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_pressed;
    logic [WIDTH-1:0] w_key_nxt;
    logic [WIDTH-1:0] r_key_state;
    logic [WIDTH-1:0] r_press_pulse;
    logic             r_any_active;

    // Two-flop synchroniser; keeps running while the lanes are disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= {WIDTH{c_POL}};
            r_sync2 <= {WIDTH{c_POL}};
        end else begin
            r_sync1 <= kbus.key_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Normalise so that 1 always means pressed.
    assign w_pressed = r_sync2 ^ {WIDTH{c_POL}};

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        logic [2:0]         r_state;
        logic [2:0]         w_state_nxt;
        logic [c_CNT_W-1:0] r_cnt;
        logic [c_CNT_W-1:0] w_cnt_nxt;
        logic [c_CNT_W-1:0] w_cnt_inc;

        // Saturating increment: the counter never wraps.
        assign w_cnt_inc = (r_cnt == '1) ? r_cnt : (r_cnt + c_CNT_ONE);

        // Debounce / hold next-state logic for this lane.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            if (!kbus.enable) begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = c_CNT_ZERO;
            end else begin
                case (r_state)
                    c_S_IDLE: begin
                        if (w_pressed[gi]) begin
                            if (c_DEB_ONE) begin
                                w_state_nxt = c_S_ENTRY;
                                w_cnt_nxt   = c_CNT_ZERO;
                            end else begin
                                w_state_nxt = c_S_ARM;
                                w_cnt_nxt   = c_CNT_ONE;
                            end
                        end
                    end
                    c_S_ARM: begin
                        if (!w_pressed[gi]) begin
                            w_state_nxt = c_S_IDLE;
                            w_cnt_nxt   = c_CNT_ZERO;
                        end else if (r_cnt == c_DEB_LAST) begin
                            w_state_nxt = c_S_ENTRY;
                            w_cnt_nxt   = c_CNT_ZERO;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                    c_S_HOLD: begin
                        // Key level is ignored until the hold time has elapsed.
                        if (r_cnt == c_HOLD_LAST) begin
                            w_state_nxt = c_S_ACTIVE;
                            w_cnt_nxt   = c_CNT_ZERO;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                    c_S_ACTIVE: begin
                        if (!w_pressed[gi]) begin
                            if (c_DEB_ONE) begin
                                w_state_nxt = c_S_IDLE;
                                w_cnt_nxt   = c_CNT_ZERO;
                            end else begin
                                w_state_nxt = c_S_DISARM;
                                w_cnt_nxt   = c_CNT_ONE;
                            end
                        end
                    end
                    c_S_DISARM: begin
                        if (w_pressed[gi]) begin
                            w_state_nxt = c_S_ACTIVE;
                            w_cnt_nxt   = c_CNT_ZERO;
                        end else if (r_cnt == c_DEB_LAST) begin
                            w_state_nxt = c_S_IDLE;
                            w_cnt_nxt   = c_CNT_ZERO;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                    default: begin
                        w_state_nxt = c_S_IDLE;
                        w_cnt_nxt   = c_CNT_ZERO;
                    end
                endcase
            end
        end

        // The key reads pressed in every state from hold until release completes.
        assign w_key_nxt[gi] = (w_state_nxt == c_S_HOLD)   ||
                               (w_state_nxt == c_S_ACTIVE) ||
                               (w_state_nxt == c_S_DISARM);

        // Lane state and counter registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= c_S_IDLE;
                r_cnt   <= c_CNT_ZERO;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end
    end

    // Registered outputs; the strobe fires only on a 0->1 of key_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_state   <= '0;
            r_press_pulse <= '0;
            r_any_active  <= 1'b0;
        end else begin
            r_key_state   <= w_key_nxt;
            r_press_pulse <= w_key_nxt & ~r_key_state;
            r_any_active  <= |w_key_nxt;
        end
    end

    assign kbus.key_state   = r_key_state;
    assign kbus.press_pulse = r_press_pulse;
    assign kbus.any_active  = r_any_active;

endmodule
`default_nettype wire
